serial_logic_unit: RTL and testbench

SERIAL_LOGIC_UNIT -- requirements
Module: serial_logic_unit

---
 rtl/serial_logic_unit.sv | 111 +++++++++++
 tb/tb_serial_logic_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/serial_logic_unit.sv
// Bit-serial AND/OR/XOR/NAND unit: one result bit per clock, LSB first.
// START is accepted only in IDLE; RESULT changes only on completion.
module serial_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             bit_res;
  logic [WIDTH-1:0] acc_next;

  // Operands shift right each RUN cycle, so bit 0 is always the current bit.
  always_comb begin
    bit_res = 1'b0;
    case (op_q)
      2'b00:   bit_res = a_q[0] & b_q[0];
      2'b01:   bit_res = a_q[0] | b_q[0];
      2'b10:   bit_res = a_q[0] ^ b_q[0];
      default: bit_res = ~(a_q[0] & b_q[0]);
    endcase
  end

  assign acc_next = {bit_res, {(WIDTH-1){1'b0}}} | (acc_q >> 1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          op_d    = OP;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        acc_d = acc_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          result_d = acc_next;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign BUSY   = (state_q == S_RUN);
  assign DONE   = (state_q == S_DONE);
  assign RESULT = result_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed bench for serial_logic_unit (WIDTH=8) with hand-computed results.
module tb_serial_logic_unit;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [1:0] OP;
  logic [7:0] A;
  logic [7:0] B;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RESULT;

  int         total;
  int         bad;
  logic [7:0] last_res;

  serial_logic_unit #(.WIDTH(8)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .OP     (OP),
    .A      (A),
    .B      (B),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Entered 1ns after an edge with the DUT idle; leaves 1ns after the return-to-IDLE edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic [7:0] exp, input bit mut);
    A = a; B = b; OP = op; START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("busy_run", BUSY, 1);
      chk("done_run", DONE, 0);
      chk("result_hold", RESULT, last_res);
      if (mut && i == 3) begin
        A = ~a; B = ~b; OP = ~op;
      end
      tick();
    end
    chk("done_pulse", DONE, 1);
    chk("busy_done", BUSY, 0);
    chk("result", RESULT, exp);
    last_res = exp;
    tick();
    chk("done_low", DONE, 0);
    chk("busy_idle", BUSY, 0);
    chk("result_after", RESULT, exp);
  endtask

  initial begin
    total = 0;
    bad = 0;
    last_res = 8'h00;
    RESET = 1'b1;
    START = 1'b0;
    OP = 2'b00;
    A = 8'h00;
    B = 8'h00;
    #2;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_result", RESULT, 0);

    // START held during reset must not be accepted
    A = 8'hF0; B = 8'h3C; OP = 2'b00; START = 1'b1;
    tick();
    chk("rst_start_ign0", BUSY, 0);
    tick();
    chk("rst_start_ign1", BUSY, 0);
    RESET = 1'b0;

    // first edge after reset release accepts
    run_op(8'hF0, 8'h3C, 2'b00, 8'h30, 1'b0);
    run_op(8'hA5, 8'h0F, 2'b01, 8'hAF, 1'b0);
    run_op(8'hFF, 8'h0F, 2'b10, 8'hF0, 1'b0);
    run_op(8'hFF, 8'hFF, 2'b11, 8'h00, 1'b0);
    run_op(8'hFF, 8'hFF, 2'b00, 8'hFF, 1'b1);
    run_op(8'hF0, 8'h3C, 2'b00, 8'h30, 1'b0);
    run_op(8'h01, 8'h02, 2'b01, 8'h03, 1'b0);

    // START held high: accept every 10 cycles, DONE at phase 8, IDLE at phase 9
    A = 8'h0F; B = 8'hFF; OP = 2'b00; START = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("hold_busy", BUSY, ((k % 10) < 8) ? 1 : 0);
      chk("hold_done", DONE, ((k % 10) == 8) ? 1 : 0);
      chk("hold_result", RESULT, (k < 8) ? 8'h03 : 8'h0F);
    end
    START = 1'b0;
    last_res = 8'h0F;

    // reset between edges in RUN cycle 4
    A = 8'hFF; B = 8'hFF; OP = 2'b00; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (4) tick();
    chk("pre_abort_busy", BUSY, 1);
    #2;
    RESET = 1'b1;
    #1;
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0);
    chk("abort_result", RESULT, 0);
    tick();
    RESET = 1'b0;
    last_res = 8'h00;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("post_abort_done", DONE, 0);
      chk("post_abort_busy", BUSY, 0);
      chk("post_abort_result", RESULT, 0);
    end

    run_op(8'h5A, 8'hFF, 2'b10, 8'hA5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
